// File: rtl/vip_window_ctrl.sv
// Sequencing controller for the 3x3 line-buffer window generator: decodes the
// vsync/href/clken stream, gates pixels to the nominal geometry and tags interior windows.
module vip_window_ctrl #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned WIN_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  output logic             lb_ce,
  output logic             lb_sclr,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             win_valid,
  output logic             frame_done,
  output logic             err_line_len,
  output logic             err_frame_len,
  output logic             busy
);

  localparam logic [CNT_W-1:0] W_C   = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] H_C   = CNT_W'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] TWO_C = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic             vsync_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] col_d, row_d, row_inc;
  logic             sclr_d, fd_d, el_d, ef_d;
  logic [WIN_LAT-1:0] tag_q;

  logic vs_rise, pix, acc, tag_c, line_end, frame_end;

  assign vs_rise   = per_frame_vsync & ~vsync_d;
  assign pix       = per_frame_vsync & per_frame_href & per_frame_clken & (state_q != IDLE);
  assign acc       = pix & (col_cnt < W_C) & (row_cnt < H_C);
  assign tag_c     = acc & (row_cnt >= TWO_C) & (col_cnt >= TWO_C);
  assign line_end  = (state_q == ACTIVE) & (~per_frame_href | ~per_frame_vsync);
  assign frame_end = (state_q != IDLE) & ~per_frame_vsync;
  assign row_inc   = (row_cnt == H_C) ? row_cnt : row_cnt + ONE_C;

  assign lb_ce     = acc;
  assign busy      = (state_q != IDLE);
  assign win_valid = tag_q[WIN_LAT-1];

  // Next state, counters and event pulses
  always_comb begin
    state_d = state_q;
    col_d   = col_cnt;
    row_d   = row_cnt;
    ovf_d   = ovf_q;
    sclr_d  = 1'b0;
    fd_d    = 1'b0;
    el_d    = 1'b0;
    ef_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d = WAIT_LINE;
          col_d   = '0;
          row_d   = '0;
          ovf_d   = 1'b0;
          sclr_d  = 1'b1;
        end
      end
      WAIT_LINE: begin
        if (!per_frame_vsync)     state_d = IDLE;
        else if (per_frame_href)  state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!per_frame_vsync)     state_d = IDLE;
        else if (!per_frame_href) state_d = WAIT_LINE;
      end
      default: state_d = IDLE;
    endcase

    if (acc) col_d = col_cnt + ONE_C;
    // col_cnt stops at the width, so an overrun needs its own sticky flag
    if (pix && (col_cnt >= W_C)) ovf_d = 1'b1;

    if (line_end) begin
      col_d = '0;
      row_d = row_inc;
      ovf_d = 1'b0;
      el_d  = (col_cnt != W_C) | ovf_q;
    end

    if (frame_end) begin
      fd_d = 1'b1;
      ef_d = ((line_end ? row_inc : row_cnt) != H_C);
    end
  end

  // vsync_d resets high so a frame already in progress at reset release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vsync_d       <= 1'b1;
      ovf_q         <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      lb_sclr       <= 1'b1;
      frame_done    <= 1'b0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      tag_q         <= '0;
    end else begin
      state_q       <= state_d;
      vsync_d       <= per_frame_vsync;
      ovf_q         <= ovf_d;
      col_cnt       <= col_d;
      row_cnt       <= row_d;
      lb_sclr       <= sclr_d;
      frame_done    <= fd_d;
      err_line_len  <= el_d;
      err_frame_len <= ef_d;
      tag_q[0]      <= tag_c;
      for (int unsigned i = 1; i < WIN_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

endmodule

// File: tb/tb_vip_window_ctrl.sv
// Directed bench for vip_window_ctrl at W=8, H=6, WIN_LAT=2.
module tb_vip_window_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic          lb_ce, lb_sclr, win_valid, frame_done, err_line_len, err_frame_len, busy;
  logic [CW-1:0] col_cnt, row_cnt;

  vip_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW), .WIN_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .lb_ce(lb_ce), .lb_sclr(lb_sclr), .col_cnt(col_cnt), .row_cnt(row_cnt),
    .win_valid(win_valid), .frame_done(frame_done), .err_line_len(err_line_len),
    .err_frame_len(err_frame_len), .busy(busy)
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  logic exp_acc = 1'b0, exp_tag = 1'b0;
  bit   kill = 1'b0;

  // Monitor: per-cycle expectations for lb_ce / win_valid, plus pulse counters
  logic [1:0] ep = 2'b00;
  int n_ce = 0, n_wv = 0, n_fd = 0, n_el = 0, n_ef = 0, n_sclr = 0, ce_bad = 0, wv_bad = 0;
  always @(negedge clk) begin
    if (!rst_n) ep = 2'b00;
    else begin
      if (lb_ce !== exp_acc) ce_bad++;
      if (win_valid !== ep[1]) wv_bad++;
      ep = {ep[0], exp_tag};
      if (lb_ce)         n_ce++;
      if (win_valid)     n_wv++;
      if (frame_done)    n_fd++;
      if (err_line_len)  n_el++;
      if (err_frame_len) n_ef++;
      if (lb_sclr)       n_sclr++;
    end
  end

  int b_ce, b_wv, b_fd, b_el, b_ef, b_sclr, b_cb, b_wb;
  task automatic snap();
    b_ce = n_ce; b_wv = n_wv; b_fd = n_fd; b_el = n_el;
    b_ef = n_ef; b_sclr = n_sclr; b_cb = ce_bad; b_wb = wv_bad;
  endtask

  task automatic cyc(input logic v, input logic h, input logic c, input logic ea, input logic et);
    @(posedge clk); #1;
    vs = v; hr = h; ce = c; exp_acc = ea; exp_tag = et;
  endtask

  task automatic pix(input int l, input int p);
    logic a;
    a = !kill && (p < int'(W)) && (l < int'(H));
    cyc(1, 1, 1, a, a && l >= 2 && p >= 2);
  endtask

  task automatic line(input int l, input int n, input bit tog);
    for (int p = 0; p < n; p++) begin
      pix(l, p);
      if (tog) cyc(1, 1, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic frame_start();
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic frame_stop();
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
  endtask

  // Shared delta checks on the frame counters (called by each frame test)
  task automatic check_frame(input string nm, input int ece, input int ewv, input int efd,
                             input int eel, input int eef, input int erow);
    total++; if (n_ce - b_ce !== ece) begin bad++; $display("FAIL %s lb_ce count: got %0d exp %0d", nm, n_ce - b_ce, ece); end
    total++; if (n_wv - b_wv !== ewv) begin bad++; $display("FAIL %s win_valid count: got %0d exp %0d", nm, n_wv - b_wv, ewv); end
    total++; if (n_fd - b_fd !== efd) begin bad++; $display("FAIL %s frame_done count: got %0d exp %0d", nm, n_fd - b_fd, efd); end
    total++; if (eel >= 0 && n_el - b_el !== eel) begin bad++; $display("FAIL %s err_line_len count: got %0d exp %0d", nm, n_el - b_el, eel); end
    total++; if (n_ef - b_ef !== eef) begin bad++; $display("FAIL %s err_frame_len count: got %0d exp %0d", nm, n_ef - b_ef, eef); end
    total++; if (ce_bad - b_cb !== 0) begin bad++; $display("FAIL %s lb_ce timing: %0d bad cycles exp 0", nm, ce_bad - b_cb); end
    total++; if (wv_bad - b_wb !== 0) begin bad++; $display("FAIL %s win_valid timing: %0d bad cycles exp 0", nm, wv_bad - b_wb); end
    total++; if (int'(row_cnt) !== erow) begin bad++; $display("FAIL %s row_cnt: got %0d exp %0d", nm, row_cnt, erow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy after frame: got %0b exp 0", nm, busy); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({lb_sclr, lb_ce, win_valid, frame_done, err_line_len, err_frame_len, busy} !== 7'b1000000)
      begin bad++; $display("FAIL reset flags: got %b exp 1000000", {lb_sclr, lb_ce, win_valid, frame_done, err_line_len, err_frame_len, busy}); end
    total++;
    if ({col_cnt, row_cnt} !== '0) begin bad++; $display("FAIL reset counters: got col=%0d row=%0d exp 0/0", col_cnt, row_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (lb_sclr !== 1'b0) begin bad++; $display("FAIL sclr release: got %b exp 0", lb_sclr); end
  endtask

  task automatic test_nominal();
    snap();
    cyc(1, 0, 0, 0, 0);
    total++; if (lb_sclr !== 1'b0) begin bad++; $display("FAIL sclr at rise: got %b exp 0", lb_sclr); end
    cyc(1, 0, 0, 0, 0);
    total++; if (lb_sclr !== 1'b1) begin bad++; $display("FAIL sclr at rise+1: got %b exp 1", lb_sclr); end
    cyc(1, 0, 0, 0, 0);
    total++; if ({lb_sclr, busy} !== 2'b01) begin bad++; $display("FAIL sclr/busy at rise+2: got %b exp 01", {lb_sclr, busy}); end
    for (int l = 0; l < int'(H); l++) line(l, W, 0);
    frame_stop();
    total++; if (n_sclr - b_sclr !== 1) begin bad++; $display("FAIL nominal sclr count: got %0d exp 1", n_sclr - b_sclr); end
    check_frame("nominal", W*H, (W-2)*(H-2), 1, 0, 0, H);
  endtask

  task automatic test_clken_toggle();
    snap();
    frame_start();
    for (int l = 0; l < int'(H); l++) line(l, W, 1);
    frame_stop();
    check_frame("toggle", W*H, (W-2)*(H-2), 1, 0, 0, H);
  endtask

  task automatic test_line_overrun();
    snap();
    frame_start();
    for (int l = 0; l < int'(H); l++) line(l, (l == 2) ? W + 2 : W, 0);
    frame_stop();
    check_frame("overrun", W*H, (W-2)*(H-2), 1, 1, 0, H);
  endtask

  task automatic test_short_frame();
    snap();
    frame_start();
    for (int l = 0; l < 3; l++) line(l, W, 0);
    for (int p = 0; p < 5; p++) pix(3, p);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    total++;
    if ({frame_done, err_line_len, err_frame_len} !== 3'b111)
      begin bad++; $display("FAIL short pulses: got %b exp 111", {frame_done, err_line_len, err_frame_len}); end
    total++;
    if (col_cnt !== '0) begin bad++; $display("FAIL short col_cnt: got %0d exp 0", col_cnt); end
    frame_stop();
    check_frame("short", 3*W + 5, (W-2) + 3, 1, 1, 1, 4);
  endtask

  task automatic test_extra_lines();
    snap();
    frame_start();
    for (int l = 0; l < int'(H) + 2; l++) line(l, W, 0);
    frame_stop();
    check_frame("extra", W*H, (W-2)*(H-2), 1, -1, 0, H);
  endtask

  task automatic test_reset_mid_frame();
    frame_start();
    line(0, W, 0);
    line(1, W, 0);
    for (int p = 0; p < 3; p++) pix(2, p);
    kill = 1'b1;
    cyc(1, 1, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({lb_sclr, lb_ce, win_valid, frame_done, err_line_len, err_frame_len, busy} !== 7'b1000000)
      begin bad++; $display("FAIL midreset flags: got %b exp 1000000", {lb_sclr, lb_ce, win_valid, frame_done, err_line_len, err_frame_len, busy}); end
    total++;
    if ({col_cnt, row_cnt} !== '0) begin bad++; $display("FAIL midreset counters: got col=%0d row=%0d exp 0/0", col_cnt, row_cnt); end
    cyc(1, 1, 1, 0, 0);
    rst_n = 1'b1;
    pix(2, 4);
    snap();
    for (int p = 5; p < int'(W); p++) pix(2, p);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
    for (int l = 3; l < int'(H); l++) line(l, W, 0);
    frame_stop();
    total++; if (n_ce - b_ce !== 0) begin bad++; $display("FAIL killed lb_ce count: got %0d exp 0", n_ce - b_ce); end
    total++; if (n_fd - b_fd !== 0) begin bad++; $display("FAIL killed frame_done count: got %0d exp 0", n_fd - b_fd); end
    total++; if (n_sclr - b_sclr !== 0) begin bad++; $display("FAIL killed sclr count: got %0d exp 0", n_sclr - b_sclr); end
    kill = 1'b0;
    snap();
    frame_start();
    for (int l = 0; l < int'(H); l++) line(l, W, 0);
    frame_stop();
    check_frame("after_reset", W*H, (W-2)*(H-2), 1, 0, 0, H);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clken_toggle();
    test_line_overrun();
    test_short_frame();
    test_extra_lines();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
